vga_timing_gen: RTL
===================

# vga_timing_gen

Parametrised video timing and test-pattern generator: the successor to the fixed 640x480 sync generator. It drives the `hsync`/`vsync`/`vde`/RGB inputs of the VGA-to-HDMI converter. Resolution, porch widths and sync polarities come from parameters. It adds a pixel-clock enable, four runtime-selectable test patterns, a frame-synchronous mode switch, a start-of-frame pulse and a frame counter.

## Interface
- `H_ACTIVE`, 640, visible pixels per line; must be a multiple of 8
- `H_FP`, 16, horizontal front porch (clocks)
- `H_SYNC`, 96, horizontal sync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, visible lines
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width
- `V_BP`, 33, vertical back porch
- `HS_POL`, 0, hsync asserted level (0 = active-low)
- `VS_POL`, 0, vsync asserted level
- `CW`, 10, counter / `px` / `py` width; must hold H_TOTAL-1 and V_TOTAL-1
- `clk`  in  1  pixel-domain clock
- `rst`  in  1  asynchronous, active-low reset
- `en`  in  1  pixel enable; the block advances only on cycles with `en`=1
- `mode`  in  2  pattern select, sampled at frame start
- `solid_rgb`  in  24  colour for mode 0, {R,G,B}
- `hsync`, `vsync`  out  1  sync outputs with parameter polarity
- `vde`  out  1  active-video flag
- `px`, `py`  out  CW  current counter position (valid in blanking too)
- `red`, `green`, `blue`  out  8 each  pixel colour; 0 when `vde`=0
- `sof`  out  1  one-enable pulse on the first active pixel of each frame
- `frame_cnt`  out  8  completed frames, wraps at 255

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is formed the same way.
- Stage 0 holds the counters `h_cnt` and `v_cnt`. On each `en` cycle, `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments; `v_cnt` wraps to 0 at V_TOTAL-1.
- Stage 1 is the output register. Every output is computed from the stage-0 values and registered together, so all outputs stay mutually coherent.
- Sync windows:
  - hsync is asserted when H_ACTIVE+H_FP <= h_cnt <= H_ACTIVE+H_FP+H_SYNC-1.
  - vsync is asserted when V_ACTIVE+V_FP <= v_cnt <= V_ACTIVE+V_FP+V_SYNC-1.
  - The output equals the POL parameter when asserted and its inverse otherwise.
- `vde` = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
- Mode register: `mode` is latched only on the `en` cycle where h_cnt=0 and v_cnt=0. A mid-frame change of `mode` takes effect at the next frame.
- Patterns (active region only):
  - 0 solid: output `solid_rgb`.
  - 1 colour bars: 8 vertical bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (components 0xFF or 0x00). The bar index comes from a 3-bit bar counter plus a width counter that reset at h_cnt=0. No divider is used.
  - 2 checkerboard: white if px[5]^py[5], else black (32x32 squares).
  - 3 gradient: red=h_cnt[7:0], green=v_cnt[7:0], blue=frame_cnt.
- `frame_cnt` increments on the `en` cycle where the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It wraps from 255 to 0.
- `sof` is 1 for exactly one output cycle, aligned with the output of position (0,0), and only when that update is an `en` cycle.
- `en`=0: counters, mode and all outputs hold their values, except `sof`, which drops to 0.

## Timing
- Reset values: counters 0; `hsync`=~HS_POL, `vsync`=~VS_POL; `vde` 0; `px`/`py` 0; RGB 0; `sof` 0; `frame_cnt` 0; mode register 0.
- Reset release: the first `en` cycle after reset outputs position (0,0), with `vde`=1 and `sof`=1.
- Latency: position (h,v) appears on `px`/`py` together with its `vde`, syncs and RGB, exactly one `en` cycle after the counters hold (h,v).
- Reset asserted mid-frame returns all state to the reset values immediately (asynchronous). The frame restarts at (0,0).
- Consecutive `sof` pulses are exactly H_TOTAL×V_TOTAL `en` cycles apart. This is 420000 at the defaults.

## Test plan
- Defaults, `en`=1, 2 frames:
  - `hsync` low for 96 clocks starting at px=656.
  - `vsync` low for lines 490-491.
  - `vde` high for 640×480 pixels per frame.
  - `sof` period 420000 clocks; `frame_cnt` 0→1→2.
- Mode 1: line 0 shows RGB FFFFFF at px 0-79, FFFF00 at px 80-159, and 000000 at px 560-639. RGB is 0 at px 640-799.
- Write `mode` from 0 to 2 at line 100: the rest of that frame stays solid, and the next frame starts checkerboard. px=32, py=0 gives FFFFFF; px=32, py=32 gives 000000.
- `en` toggling 1,0,0,1 repeatedly: outputs hold during `en`=0, `sof` is never high when `en`=0, and the `sof` period counted in `en` cycles is still 420000.
- Assert `rst` low at px=300, py=200, hold 3 clocks, release:
  - outputs are at reset values during reset;
  - the first `en` cycle afterwards gives px=0, py=0, `sof`=1, `frame_cnt`=0.
- Non-default parameters (H_ACTIVE=800, H_FP=40, H_SYNC=128, H_BP=88, V 600/1/4/23, HS_POL=VS_POL=1, CW=11):
  - `hsync` high at px 840-967;
  - line length 1056, frame 628 lines.

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Parametrised video timing and test-pattern generator. Two
//             pipeline stages: stage 0 holds the raster counters, the
//             pattern mode register and the frame counter; stage 1 registers
//             every output together so sync, position, vde and colour always
//             describe the same pixel.
//  Ports    : clk        pixel-domain clock
//             rst        asynchronous active-low reset
//             en         pixel enable; nothing advances when low
//             mode       pattern select (0 solid, 1 bars, 2 checker, 3 ramp),
//                        sampled at the start of each frame
//             solid_rgb  {R,G,B} colour for mode 0
//             hsync      horizontal sync, asserted level = HS_POL
//             vsync      vertical sync, asserted level = VS_POL
//             vde        active-video flag
//             px, py     position of the pixel currently on the outputs
//             red/green/blue  pixel colour, 0 outside the active area
//             sof        one-enable pulse with pixel (0,0)
//             frame_cnt  completed frames, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [23:0]   solid_rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          vde,
  output logic [CW-1:0] px,
  output logic [CW-1:0] py,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          sof,
  output logic [7:0]    frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_LAST_I   = H_TOTAL - 1;
  localparam int V_LAST_I   = V_TOTAL - 1;
  localparam int HS_BEG_I   = H_ACTIVE + H_FP;
  localparam int HS_END_I   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_BEG_I   = V_ACTIVE + V_FP;
  localparam int VS_END_I   = V_ACTIVE + V_FP + V_SYNC - 1;
  localparam int BAR_LAST_I = (H_ACTIVE / 8) - 1;

  localparam logic [CW-1:0] H_LAST   = H_LAST_I[CW-1:0];
  localparam logic [CW-1:0] V_LAST   = V_LAST_I[CW-1:0];
  localparam logic [CW-1:0] HS_BEG   = HS_BEG_I[CW-1:0];
  localparam logic [CW-1:0] HS_END   = HS_END_I[CW-1:0];
  localparam logic [CW-1:0] VS_BEG   = VS_BEG_I[CW-1:0];
  localparam logic [CW-1:0] VS_END   = VS_END_I[CW-1:0];
  localparam logic [CW-1:0] H_ACT    = H_ACTIVE[CW-1:0];
  localparam logic [CW-1:0] V_ACT    = V_ACTIVE[CW-1:0];
  localparam logic [CW-1:0] BAR_LAST = BAR_LAST_I[CW-1:0];

  localparam logic HS_ON = (HS_POL != 0);
  localparam logic VS_ON = (VS_POL != 0);

  // ---------------------------------------------------------------- stage 0
  logic [CW-1:0] r_h_cnt;
  logic [CW-1:0] r_v_cnt;
  logic [2:0]    r_bar;      // colour-bar index of r_h_cnt
  logic [CW-1:0] r_bar_w;    // position inside the current bar
  logic [1:0]    r_mode;
  logic [7:0]    r_frame;

  logic          w_h_last;
  logic          w_v_last;
  logic          w_origin;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_v_last = (r_v_cnt == V_LAST);
  assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
      r_bar   <= '0;
      r_bar_w <= '0;
      r_mode  <= '0;
      r_frame <= '0;
    end else if (en) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + 1'b1;
      end else begin
        r_h_cnt <= r_h_cnt + 1'b1;
      end

      // Bar index tracks h_cnt by counting bar widths, avoiding a divider.
      if (w_h_last) begin
        r_bar   <= '0;
        r_bar_w <= '0;
      end else if (r_bar_w == BAR_LAST) begin
        r_bar   <= r_bar + 1'b1;
        r_bar_w <= '0;
      end else begin
        r_bar_w <= r_bar_w + 1'b1;
      end

      if (w_origin) begin
        r_mode <= mode;
      end

      if (w_h_last && w_v_last) begin
        r_frame <= r_frame + 1'b1;
      end
    end
  end

  // ------------------------------------------------------ output decoding
  logic        w_hs_on;
  logic        w_vs_on;
  logic        w_vde;
  logic [1:0]  w_mode_eff;
  logic [23:0] w_rgb;

  assign w_hs_on = (r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END);
  assign w_vs_on = (r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END);
  assign w_vde   = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);

  // Pixel (0,0) is rendered on the same edge that latches the mode, so it
  // must see the incoming value for the whole frame to use one pattern.
  assign w_mode_eff = w_origin ? mode : r_mode;

  always_comb begin
    w_rgb = 24'h000000;
    if (w_vde) begin
      case (w_mode_eff)
        2'd0:    w_rgb = solid_rgb;
        // Bar order W,Y,C,G,M,R,B,K reduces to one inverted index bit
        // per colour component.
        2'd1:    w_rgb = {{8{~r_bar[1]}}, {8{~r_bar[2]}}, {8{~r_bar[0]}}};
        2'd2:    w_rgb = (r_h_cnt[5] ^ r_v_cnt[5]) ? 24'hFFFFFF : 24'h000000;
        default: w_rgb = {r_h_cnt[7:0], r_v_cnt[7:0], r_frame};
      endcase
    end
  end

  // ---------------------------------------------------------------- stage 1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync     <= ~HS_ON;
      vsync     <= ~VS_ON;
      vde       <= 1'b0;
      px        <= '0;
      py        <= '0;
      red       <= '0;
      green     <= '0;
      blue      <= '0;
      sof       <= 1'b0;
      frame_cnt <= '0;
    end else if (en) begin
      hsync     <= w_hs_on ? HS_ON : ~HS_ON;
      vsync     <= w_vs_on ? VS_ON : ~VS_ON;
      vde       <= w_vde;
      px        <= r_h_cnt;
      py        <= r_v_cnt;
      red       <= w_rgb[23:16];
      green     <= w_rgb[15:8];
      blue      <= w_rgb[7:0];
      sof       <= w_origin;
      frame_cnt <= r_frame;
    end else begin
      sof       <= 1'b0;
    end
  end

endmodule
`default_nettype wire
